// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard unit: forwarding selects,
// FSM states, shadow-stage payloads and producer/forward-match functions.
package hazard_pkg;

  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } hz_state_t;

  // Stage payloads; the valid bit lives separately inside hz_shadow_stage.
  typedef struct packed {
    logic [4:0] rn;
    logic [4:0] rm;
    logic       use_a;
    logic       use_b;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } idex_stage_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
  } wb_stage_t;

  localparam int IDEX_W = $bits(idex_stage_t);
  localparam int WB_W   = $bits(wb_stage_t);

  function automatic logic is_producer(input logic valid, input logic reg_write,
                                       input logic [4:0] rd);
    return valid & reg_write & (rd != XZR);
  endfunction

  function automatic fwd_sel_t fwd_pick(input logic use_src, input logic [4:0] src,
                                        input logic exmem_prod, input logic [4:0] exmem_rd,
                                        input logic memwb_prod, input logic [4:0] memwb_rd);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (use_src && exmem_prod && (src == exmem_rd)) begin
      sel = FWD_EXMEM;
    end else if (use_src && memwb_prod && (src == memwb_rd)) begin
      sel = FWD_MEMWB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hz_shadow_stage.sv
// One shadow pipeline stage: a valid bit plus W payload bits, cleared
// asynchronously by reset and reloaded every cycle.
module hz_shadow_stage #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_d,
  input  logic [W-1:0] data_d,
  output logic         valid_q,
  output logic [W-1:0] data_q
);

  // Stage register; advances unconditionally, the caller injects bubbles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= {W{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stall and taken-branch
// flush, driven by three shadow stages that mirror ID/EX, EX/MEM and MEM/WB.
module hazard_unit
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_d,
  input  logic [4:0]  Rn_d,
  input  logic [4:0]  Rm_d,
  input  logic        useA_d,
  input  logic        useB_d,
  input  logic [4:0]  Rd_d,
  input  logic        RegWrite_d,
  input  logic        MemRead_d,
  input  logic        brTaken_x,
  output logic [1:0]  fwdA_x,
  output logic [1:0]  fwdB_x,
  output logic        pcWrite,
  output logic        ifidWrite,
  output logic        ifidFlush,
  output logic        idexBubble,
  output logic [1:0]  state,
  output logic [15:0] bubbleCnt
);

  hz_state_t         state_q, state_d;
  logic [15:0]       bubble_cnt_q, bubble_cnt_d;

  logic              idex_valid_q, exmem_valid_q, memwb_valid_q;
  logic [IDEX_W-1:0] idex_bits_q;
  logic [WB_W-1:0]   exmem_bits_q, memwb_bits_q;
  idex_stage_t       idex_q, idex_in_s, idex_d;
  wb_stage_t         exmem_q, memwb_q, exmem_d;
  logic              idex_valid_d;

  logic              load_use_s, exmem_prod_s, memwb_prod_s;

  assign idex_q  = idex_stage_t'(idex_bits_q);
  assign exmem_q = wb_stage_t'(exmem_bits_q);
  assign memwb_q = wb_stage_t'(memwb_bits_q);

  assign idex_in_s = '{rn: Rn_d, rm: Rm_d, use_a: useA_d, use_b: useB_d,
                       rd: Rd_d, reg_write: RegWrite_d, mem_read: MemRead_d};
  assign exmem_d   = '{rd: idex_q.rd, reg_write: idex_q.reg_write};

  assign exmem_prod_s = is_producer(exmem_valid_q, exmem_q.reg_write, exmem_q.rd);
  assign memwb_prod_s = is_producer(memwb_valid_q, memwb_q.reg_write, memwb_q.rd);

  assign fwdA_x = fwd_pick(idex_valid_q & idex_q.use_a, idex_q.rn,
                           exmem_prod_s, exmem_q.rd, memwb_prod_s, memwb_q.rd);
  assign fwdB_x = fwd_pick(idex_valid_q & idex_q.use_b, idex_q.rm,
                           exmem_prod_s, exmem_q.rd, memwb_prod_s, memwb_q.rd);

  // A matching Rd implies the source is not XZR, since Rd is already checked.
  assign load_use_s = idex_valid_q & idex_q.mem_read & (idex_q.rd != XZR) & valid_d &
                      ((useA_d & (Rn_d == idex_q.rd)) | (useB_d & (Rm_d == idex_q.rd)));

  // Pipeline control and next state; reset forces the quiescent RUN controls.
  always_comb begin
    pcWrite      = 1'b1;
    ifidWrite    = 1'b1;
    ifidFlush    = 1'b0;
    idexBubble   = 1'b0;
    idex_valid_d = valid_d;
    idex_d       = idex_in_s;
    state_d      = RUN;
    if (!reset) begin
      idex_valid_d = 1'b0;
      idex_d       = '0;
    end else if (brTaken_x) begin
      ifidFlush    = 1'b1;
      idexBubble   = 1'b1;
      idex_valid_d = 1'b0;
      idex_d       = '0;
      state_d      = FLUSH;
    end else if (load_use_s) begin
      pcWrite      = 1'b0;
      ifidWrite    = 1'b0;
      idexBubble   = 1'b1;
      idex_valid_d = 1'b0;
      idex_d       = '0;
      state_d      = STALL;
    end else begin
      state_d      = RUN;
    end
  end

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (idexBubble && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end else begin
      bubble_cnt_d = bubble_cnt_q;
    end
  end

  // FSM state and bubble counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RUN;
      bubble_cnt_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign state     = state_q;
  assign bubbleCnt = bubble_cnt_q;

  hz_shadow_stage #(.W(IDEX_W)) u_idex (
    .clk(clk), .reset(reset), .valid_d(idex_valid_d), .data_d(idex_d),
    .valid_q(idex_valid_q), .data_q(idex_bits_q)
  );

  hz_shadow_stage #(.W(WB_W)) u_exmem (
    .clk(clk), .reset(reset), .valid_d(idex_valid_q), .data_d(exmem_d),
    .valid_q(exmem_valid_q), .data_q(exmem_bits_q)
  );

  hz_shadow_stage #(.W(WB_W)) u_memwb (
    .clk(clk), .reset(reset), .valid_d(exmem_valid_q), .data_d(exmem_q),
    .valid_q(memwb_valid_q), .data_q(memwb_bits_q)
  );

endmodule
